// File: rtl/wire_alu_pkg.sv
// Shared encodings for the host-driven ALU stage: op codes, ctrl/status bit
// positions and the controller state type.
package wire_alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_ACC = 2'b11;

  localparam int GO_BIT  = 0;
  localparam int OP_LSB  = 1;
  localparam int CLR_BIT = 3;

  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_FLAG    = 2;
  localparam int ST_DROP    = 3;
  localparam int ST_LOP_LSB = 8;
  localparam int ST_CNT_LSB = 16;

  localparam int MUL_CNT_W = 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_MUL  = 2'b10
  } state_t;

endpackage

// File: rtl/wire_alu_mul_seq.sv
// Iterative shift-add unsigned multiplier: one multiplier bit per cycle, LSB first.
// o_done pulses for one cycle with the full product valid in that cycle.
module wire_alu_mul_seq
  import wire_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_prod
);

  logic                 r_run;
  logic                 r_done;
  logic [MUL_CNT_W-1:0] r_cnt;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   r_prod;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_run  <= 1'b0;
      r_done <= 1'b0;
      r_cnt  <= '0;
    end else if (i_abort) begin
      r_run  <= 1'b0;
      r_done <= 1'b0;
    end else if (i_start) begin
      r_run  <= 1'b1;
      r_done <= 1'b0;
      r_cnt  <= '0;
    end else if (r_run) begin
      r_cnt <= r_cnt + MUL_CNT_W'(1);
      if (r_cnt == MUL_CNT_W'(WIDTH - 1)) begin
        r_run  <= 1'b0;
        r_done <= 1'b1;
      end
    end else begin
      r_done <= 1'b0;
    end
  end

  // Operand/product registers carry data only and need no reset.
  always_ff @(posedge i_clk) begin
    if (i_start) begin
      r_mcand  <= {{WIDTH{1'b0}}, i_a};
      r_mplier <= i_b;
      r_prod   <= '0;
    end else if (r_run) begin
      if (r_mplier[0]) r_prod <= r_prod + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
    end
  end

  assign o_done = r_done;
  assign o_prod = r_prod;

endmodule

// File: rtl/wire_alu_stage.sv
// Host-polled ALU stage: edge-detects go/clr from the control WireIn and runs
// add/sub/acc in one cycle or an iterative multiply, exposing result and status.
module wire_alu_stage
  import wire_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             okClk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [31:0]      ctrl,
  output logic [WIDTH-1:0] result,
  output logic [31:0]      status
);

  state_t             r_state, w_next;
  logic               r_go_d, r_clr_d;
  logic [WIDTH-1:0]   r_a, r_b, r_acc, r_result;
  logic [1:0]         r_op, r_last_op;
  logic               r_flag, r_done, r_dropped;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_go_rise, w_clr_rise, w_mul_start, w_mul_done;
  logic [1:0]         w_op_in;
  logic [WIDTH:0]     w_sum, w_diff, w_acc_sum;
  logic [2*WIDTH-1:0] w_prod;
  logic               w_unused;

  assign w_go_rise   = ctrl[GO_BIT] & ~r_go_d;
  assign w_clr_rise  = ctrl[CLR_BIT] & ~r_clr_d;
  assign w_op_in     = ctrl[OP_LSB +: 2];
  assign w_mul_start = (r_state == S_IDLE) & w_go_rise & ~w_clr_rise & (w_op_in == OP_MUL);
  assign w_unused    = ^{ctrl[31:4]};

  assign w_sum     = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff    = {1'b0, r_a} - {1'b0, r_b};
  assign w_acc_sum = {1'b0, r_acc} + {1'b0, r_a};

  wire_alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .i_clk   (okClk),
    .i_rst_n (rst_n),
    .i_start (w_mul_start),
    .i_abort (w_clr_rise),
    .i_a     (op_a),
    .i_b     (op_b),
    .o_done  (w_mul_done),
    .o_prod  (w_prod)
  );

  always_comb begin
    w_next = r_state;
    if (w_clr_rise) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_go_rise) w_next = (w_op_in == OP_MUL) ? S_MUL : S_EXEC;
        S_EXEC:  w_next = S_IDLE;
        S_MUL:   if (w_mul_done) w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge okClk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Operands are captured at the accepted go edge so later WireIn writes are ignored.
  always_ff @(posedge okClk) begin
    if ((r_state == S_IDLE) && w_go_rise && !w_clr_rise) begin
      r_a  <= op_a;
      r_b  <= op_b;
      r_op <= w_op_in;
    end
  end

  always_ff @(posedge okClk or negedge rst_n) begin
    if (!rst_n) begin
      r_go_d    <= 1'b0;
      r_clr_d   <= 1'b0;
      r_acc     <= '0;
      r_result  <= '0;
      r_flag    <= 1'b0;
      r_done    <= 1'b0;
      r_dropped <= 1'b0;
      r_cnt     <= '0;
      r_last_op <= OP_ADD;
    end else begin
      r_go_d  <= ctrl[GO_BIT];
      r_clr_d <= ctrl[CLR_BIT];
      if (w_clr_rise) begin
        r_acc     <= '0;
        r_result  <= '0;
        r_flag    <= 1'b0;
        r_done    <= 1'b0;
        r_dropped <= 1'b0;
        r_cnt     <= '0;
      end else begin
        if (w_go_rise && (r_state != S_IDLE)) r_dropped <= 1'b1;
        case (r_state)
          S_IDLE: if (w_go_rise) r_done <= 1'b0;
          S_EXEC: begin
            case (r_op)
              OP_SUB: begin
                r_result <= w_diff[WIDTH-1:0];
                r_flag   <= w_diff[WIDTH];
              end
              OP_ACC: begin
                r_acc    <= w_acc_sum[WIDTH-1:0];
                r_result <= w_acc_sum[WIDTH-1:0];
                r_flag   <= w_acc_sum[WIDTH];
              end
              default: begin
                r_result <= w_sum[WIDTH-1:0];
                r_flag   <= w_sum[WIDTH];
              end
            endcase
            r_done    <= 1'b1;
            r_cnt     <= r_cnt + CNT_W'(1);
            r_last_op <= r_op;
          end
          S_MUL: if (w_mul_done) begin
            r_result  <= w_prod[WIDTH-1:0];
            r_flag    <= |w_prod[2*WIDTH-1:WIDTH];
            r_done    <= 1'b1;
            r_cnt     <= r_cnt + CNT_W'(1);
            r_last_op <= OP_MUL;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    status                          = '0;
    status[ST_BUSY]                 = (r_state != S_IDLE);
    status[ST_DONE]                 = r_done;
    status[ST_FLAG]                 = r_flag;
    status[ST_DROP]                 = r_dropped;
    status[ST_LOP_LSB +: 2]         = r_last_op;
    status[ST_CNT_LSB +: CNT_W]     = r_cnt;
  end

  assign result = r_result;

endmodule

// File: tb/tb_wire_alu_stage.sv
// Directed bench for wire_alu_stage: each task drives one scenario and checks
// result/status against hand-computed values.
module tb_wire_alu_stage;

  logic        okClk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] op_a  = '0;
  logic [31:0] op_b  = '0;
  logic [31:0] ctrl  = '0;
  logic [31:0] result;
  logic [31:0] status;

  int tests  = 0;
  int failed = 0;

  wire_alu_stage #(.WIDTH(32), .CNT_W(16)) dut (
    .okClk  (okClk),
    .rst_n  (rst_n),
    .op_a   (op_a),
    .op_b   (op_b),
    .ctrl   (ctrl),
    .result (result),
    .status (status)
  );

  always #5 okClk = ~okClk;

  task automatic tick();
    @(posedge okClk);
    #1;
  endtask

  // Present operands with go low, then raise go; returns just after edge E0.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    op_a = a; op_b = b; ctrl = {28'd0, 1'b0, op, 1'b0};
    tick();
    ctrl = {28'd0, 1'b0, op, 1'b1};
    tick();
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (status[0] && cycles < 60) begin
      cycles++;
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ctrl = '0;
    repeat (3) tick();
    tests++;
    if (result !== 32'h0) begin failed++; $display("FAIL reset_result got=%h exp=%h", result, 32'h0); end
    tests++;
    if (status !== 32'h0) begin failed++; $display("FAIL reset_status got=%h exp=%h", status, 32'h0); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_add();
    start_op(32'hFFFF_FFFF, 32'h0000_0002, 2'b00);
    tests++;
    if (status[0] !== 1'b1) begin failed++; $display("FAIL add_busy_e0 got=%b exp=1", status[0]); end
    tick();
    tests++;
    if (result !== 32'h0000_0001) begin failed++; $display("FAIL add_result got=%h exp=%h", result, 32'h1); end
    tests++;
    if (status !== 32'h0001_0006) begin failed++; $display("FAIL add_status got=%h exp=%h", status, 32'h0001_0006); end
    repeat (10) tick();
    tests++;
    if (status !== 32'h0001_0006) begin failed++; $display("FAIL add_hold_go got=%h exp=%h", status, 32'h0001_0006); end
    ctrl = '0; tick();
  endtask

  task automatic test_sub();
    start_op(32'd5, 32'd7, 2'b01);
    tick();
    tests++;
    if (result !== 32'hFFFF_FFFE) begin failed++; $display("FAIL sub_result got=%h exp=%h", result, 32'hFFFF_FFFE); end
    tests++;
    if (status !== 32'h0002_0106) begin failed++; $display("FAIL sub_status got=%h exp=%h", status, 32'h0002_0106); end
    ctrl = '0; tick();
  endtask

  task automatic test_mul();
    int n;
    start_op(32'h0001_0000, 32'h0001_0000, 2'b10);
    ctrl = '0;
    wait_idle(n);
    tests++;
    if (n != 33) begin failed++; $display("FAIL mul_busy_cycles got=%0d exp=33", n); end
    tests++;
    if (result !== 32'h0) begin failed++; $display("FAIL mul_ovf_result got=%h exp=%h", result, 32'h0); end
    tests++;
    if (status !== 32'h0003_0206) begin failed++; $display("FAIL mul_ovf_status got=%h exp=%h", status, 32'h0003_0206); end
    start_op(32'd1234, 32'd5678, 2'b10);
    ctrl = '0;
    wait_idle(n);
    tests++;
    if (result !== 32'd7006652) begin failed++; $display("FAIL mul_result got=%h exp=%h", result, 32'd7006652); end
    tests++;
    if (status !== 32'h0004_0202) begin failed++; $display("FAIL mul_status got=%h exp=%h", status, 32'h0004_0202); end
  endtask

  task automatic test_acc();
    start_op(32'd10, 32'd0, 2'b11); tick();
    start_op(32'd20, 32'd0, 2'b11); tick();
    start_op(32'd30, 32'd0, 2'b11); tick();
    tests++;
    if (result !== 32'd60) begin failed++; $display("FAIL acc_result got=%0d exp=60", result); end
    tests++;
    if (status !== 32'h0007_0302) begin failed++; $display("FAIL acc_status got=%h exp=%h", status, 32'h0007_0302); end
    ctrl = 32'h8; tick();
    tests++;
    if (result !== 32'd0) begin failed++; $display("FAIL acc_clr_result got=%0d exp=0", result); end
    tests++;
    if (status !== 32'h0000_0300) begin failed++; $display("FAIL acc_clr_status got=%h exp=%h", status, 32'h0000_0300); end
    ctrl = '0; tick();
    start_op(32'd4, 32'd0, 2'b11); tick();
    tests++;
    if (result !== 32'd4) begin failed++; $display("FAIL acc_after_clr got=%0d exp=4", result); end
    tests++;
    if (status !== 32'h0001_0302) begin failed++; $display("FAIL acc_after_clr_status got=%h exp=%h", status, 32'h0001_0302); end
    ctrl = '0; tick();
  endtask

  task automatic test_drop_abort();
    int n;
    start_op(32'd1234, 32'd5678, 2'b10);
    ctrl = 32'h4;
    repeat (8) tick();
    ctrl = 32'h5;
    tick();
    tests++;
    if (status[3:0] !== 4'b1001) begin failed++; $display("FAIL drop_flagged got=%b exp=1001", status[3:0]); end
    wait_idle(n);
    tests++;
    if (result !== 32'd7006652) begin failed++; $display("FAIL drop_mul_result got=%h exp=%h", result, 32'd7006652); end
    tests++;
    if (status !== 32'h0002_020A) begin failed++; $display("FAIL drop_status got=%h exp=%h", status, 32'h0002_020A); end
    ctrl = '0; tick();
    start_op(32'd3, 32'd4, 2'b10);
    ctrl = 32'h4;
    repeat (19) tick();
    ctrl = 32'h8;
    tick();
    tests++;
    if (status !== 32'h0000_0200) begin failed++; $display("FAIL abort_status got=%h exp=%h", status, 32'h0000_0200); end
    repeat (40) tick();
    tests++;
    if (result !== 32'h0) begin failed++; $display("FAIL abort_no_update got=%h exp=%h", result, 32'h0); end
    tests++;
    if (status !== 32'h0000_0200) begin failed++; $display("FAIL abort_status_late got=%h exp=%h", status, 32'h0000_0200); end
    ctrl = '0; tick();
  endtask

  task automatic test_clr_go_same();
    op_a = 32'd1; op_b = 32'd1; ctrl = '0;
    tick();
    ctrl = 32'h9;
    tick();
    tests++;
    if (status !== 32'h0000_0200) begin failed++; $display("FAIL clrgo_status got=%h exp=%h", status, 32'h0000_0200); end
    tick();
    tests++;
    if (status !== 32'h0000_0200) begin failed++; $display("FAIL clrgo_status_next got=%h exp=%h", status, 32'h0000_0200); end
    tests++;
    if (result !== 32'h0) begin failed++; $display("FAIL clrgo_result got=%h exp=%h", result, 32'h0); end
    ctrl = '0; tick();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_acc();
    test_drop_abort();
    test_clr_go_same();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
